// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampling UART receiver feeding a circular receive FIFO.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
//
// Handshake: ready=1 means the FIFO holds at least one character. A cycle with
// rd_en=1 and ready=1 pops one entry; valid pulses for one cycle on the next
// cycle with that entry on data, and data holds it until the next pop.
// rd_en while ready=0 is ignored.
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic                          ready,
  output logic                          valid,
  output logic [DATA_BITS-1:0]          data,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int DIV_RAW = CLK_FREQ_HZ / (BAUD_RATE * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = (PARITY_MODE != 0);
  typedef enum logic [2:0] {
    WAIT_IDLE, IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  localparam int unused_parity_mode = PARITY_MODE;
  typedef enum logic [2:0] {
    WAIT_IDLE, IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t                 state, state_n;
  logic                   rx_s1, rx_s2;
  logic [TW-1:0]          tick_cnt;
  logic                   tick, clr_tick;
  logic [3:0]             os_cnt, os_n;
  logic [3:0]             bit_cnt, bit_n;
  logic [DATA_BITS-1:0]   shreg, sh_n;
  logic                   par_bad, par_n;
  logic                   push, fe;
`ifdef UART_RX_PARITY_EN
  logic                   pe;
`endif

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [LW-1:0]          count;
  logic                   full, pop_ok, wr_ok;

  // Two-flop synchroniser for the asynchronous line, idling high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  assign tick = (tick_cnt == TW'(DIV - 1));

  // Oversample tick divider; restarted on each start-bit detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tick_cnt <= '0;
    else if (clr_tick || tick) tick_cnt <= '0;
    else                       tick_cnt <= tick_cnt + 1'b1;
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT_IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      state   <= state_n;
      os_cnt  <= os_n;
      bit_cnt <= bit_n;
      shreg   <= sh_n;
      par_bad <= par_n;
    end
  end

  // Next-state logic: START samples after 8 ticks (mid-bit), later bits every 16.
  always_comb begin
    state_n  = state;
    os_n     = os_cnt;
    bit_n    = bit_cnt;
    sh_n     = shreg;
    par_n    = par_bad;
    clr_tick = 1'b0;
    push     = 1'b0;
    fe       = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe       = 1'b0;
`endif
    case (state)
      WAIT_IDLE: if (tick && rx_s2) state_n = IDLE;
      IDLE: begin
        if (!rx_s2) begin
          state_n  = START;
          clr_tick = 1'b1;
          os_n     = '0;
          par_n    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (os_cnt == 4'd7) begin
            os_n    = '0;
            bit_n   = '0;
            state_n = rx_s2 ? IDLE : DATA;
          end else begin
            os_n = os_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (os_cnt == 4'd15) begin
            os_n = '0;
            sh_n = {rx_s2, shreg[DATA_BITS-1:1]};
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_n = PAR_ON ? PARITY : STOP;
`else
              state_n = STOP;
`endif
            end else begin
              bit_n = bit_cnt + 4'd1;
            end
          end else begin
            os_n = os_cnt + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (os_cnt == 4'd15) begin
            os_n    = '0;
            par_n   = (PARITY_MODE == 1) ? ((^shreg) != rx_s2) : ((^shreg) == rx_s2);
            state_n = STOP;
          end else begin
            os_n = os_cnt + 4'd1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (os_cnt == 4'd15) begin
            os_n = '0;
            if (!rx_s2) begin
              fe      = 1'b1;
              state_n = WAIT_IDLE;
            end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
              pe      = 1'b1;
`endif
              state_n = IDLE;
            end else begin
              push    = 1'b1;
              state_n = IDLE;
            end
          end else begin
            os_n = os_cnt + 4'd1;
          end
        end
      end
      default: state_n = WAIT_IDLE;
    endcase
  end

  assign ready  = (count != '0);
  assign level  = count;
  assign full   = (count == LW'(FIFO_DEPTH));
  assign pop_ok = rd_en && ready;
  assign wr_ok  = push && (!full || pop_ok);

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers, occupancy, read port and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid     <= 1'b0;
      data      <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        data   <= mem[rd_ptr];
      end
      count     <= count + LW'(wr_ok) - LW'(pop_ok);
      valid     <= pop_ok;
      overrun   <= push && full && !pop_ok;
      frame_err <= fe;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error pulse, aligned with the would-be push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= pe;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with integrated receive FIFO. It deserialises an asynchronous serial line using 16x oversampling and configurable frame format, buffers completed characters, and presents them to the controller through the rd_en/ready/valid/data pull handshake of the UART RX interface. It sits between the board RX pin and the controller-side RX modport, and replaces the fixed 8-bit, unbuffered receive path.

## Interface
- CLK_FREQ_HZ, 50_000_000, system clock frequency.
- BAUD_RATE, 115_200, line rate; tick divider DIV = CLK_FREQ_HZ / (BAUD_RATE*16), integer division, minimum 1.
- DATA_BITS, 8, character width, legal 5..9.
- PARITY_MODE, 0, parity mode: 0 none, 1 even, 2 odd. Only effective with UART_RX_PARITY_EN.
- FIFO_DEPTH, 16, number of FIFO entries; power of two, at least 2.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  serial input, idle high, asynchronous to clk.
- rd_en  in  1  controller pop request.
- ready  out  1  FIFO non-empty.
- valid  out  1  one-cycle pulse, data holds a popped character.
- data  out  DATA_BITS  popped character, LSB = first received bit.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_err  out  1  one-cycle pulse on bad stop bit.
- parity_err  out  1  one-cycle pulse on parity mismatch.
- overrun  out  1  one-cycle pulse when a good character is dropped because the FIFO is full.

## Operation
- rx passes through a 2-flop synchroniser; both flops reset to 1.
- The tick counter counts 0..DIV-1 and asserts tick for one cycle at DIV-1. Reset and every IDLE->START transition clear it.
- FSM states: WAIT_IDLE, IDLE, START, DATA, PARITY, STOP.
  - WAIT_IDLE is the reset state. It goes to IDLE once the synchronised line is high on a tick.
  - IDLE goes to START when the synchronised line is low.
  - START counts 8 ticks, then samples mid-bit. Low goes to DATA; high is a glitch and goes back to IDLE with no error.
  - DATA samples every 16 ticks, DATA_BITS samples, LSB first, into a shift register.
  - After DATA, the FSM goes to PARITY if parity is enabled, otherwise to STOP.
  - PARITY samples one bit and compares it with the XOR of the data. Even mode expects XOR==bit; odd mode expects XOR!=bit.
  - STOP samples one bit. If it is high and parity is good, the character is pushed and the FSM goes to IDLE. If it is low, frame_err pulses, the character is discarded, and the FSM goes to WAIT_IDLE. If it is high but parity failed, parity_err pulses, the character is discarded, and the FSM goes to IDLE.
- When both errors occur in one character, only frame_err pulses.
- The FIFO is a circular buffer with pointers of width $clog2(FIFO_DEPTH) that wrap naturally. level is tracked in a separate counter.
- Pops are accepted only when ready=1. rd_en on an empty FIFO is ignored, valid stays 0, and the pointers do not change.

## Timing
- Reset values: ready 0, valid 0, data 0, level 0, frame_err 0, parity_err 0, overrun 0. The FSM is in WAIT_IDLE and the FIFO is empty.
- Push happens on the clock after the stop sample tick. ready and level update on that same edge.
- Read latency is one cycle. With rd_en=1 and ready=1 in cycle N, valid=1 and data is valid in cycle N+1. data holds that value until the next pop.
- Back-to-back pops are allowed, one per cycle.
- Full FIFO with push and pop in the same cycle: both occur, level stays at FIFO_DEPTH, and there is no overrun.
- Full FIFO with push and no pop: the character is dropped, overrun pulses, and stored data is unchanged.
- Empty FIFO with push and pop in the same cycle: the pop is ignored and the push is stored, so level becomes 1.
- Non-full, non-empty FIFO with push and pop together: level is unchanged.
- Error pulses assert on the same cycle the push would have occurred.
- Reset asserted mid-frame aborts the character, empties the FIFO, clears all outputs immediately, and leaves the FSM in WAIT_IDLE.
- Total latency from the start-bit edge to ready is about (1 + DATA_BITS + parity + 1) x 16 x DIV cycles, minus 8 ticks, plus 3 cycles for the synchroniser and push.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY state and its checker are compiled in, and PARITY_MODE selects none, even or odd.
- UART_RX_PARITY_EN undefined: the PARITY state is absent, PARITY_MODE is ignored, the frame is treated as having no parity bit, and parity_err is tied to 0.

## Test plan
All scenarios use CLK_FREQ_HZ=16_000_000 and BAUD_RATE=1_000_000, so DIV=1 and one bit lasts 16 clocks.
- Send 0xA5, 8N1, then pulse rd_en -> ready=1 and level=1 after the stop bit; valid pulses the next cycle with data=0xA5; then ready=0 and level=0.
- Drive rx low for 4 clocks, then high -> no push, no error pulses, FSM returns to IDLE.
- Send 0x3C with the stop bit driven low -> frame_err pulses once, level stays 0; after rx returns high, 0x11 is received correctly.
- FIFO_DEPTH=4: send 0x01..0x05 without reading -> overrun pulses on the 5th character; four pops return 0x01, 0x02, 0x03, 0x04 in order.
- With UART_RX_PARITY_EN and PARITY_MODE=1: send 0x01 with parity bit 0 -> parity_err pulses and nothing is pushed; send 0x01 with parity bit 1 -> data=0x01 is received.
- Assert rst_n low during DATA bit 3 of 0x7E -> all outputs are 0 immediately; after release and a full idle period, 0x55 is received correctly.
